// File: rtl/drop_sequencer_if.sv
// Handshake and data bundle between the sensor front end, drop_sequencer and the drop stage.
// The err signal only carries information when DROP_SEQ_ZERO_HEIGHT_GUARD_EN is defined.
interface drop_sequencer_if;
   logic        start;
   logic        abort;
   logic [7:0]  height;
   logic [15:0] t_lim;
   logic        drop_en;
   logic        busy;
   logic        done;
   logic [15:0] t_act;
   logic        drop_activated;
   logic        err;

   modport master (
      output start, abort, height, t_lim, drop_en,
      input  busy, done, t_act, drop_activated, err
   );

   modport slave (
      input  start, abort, height, t_lim, drop_en,
      output busy, done, t_act, drop_activated, err
   );
endinterface

// File: rtl/drop_sequencer.sv
// Sequenced sqrt-and-compare drop controller: bit-serial 8.8 square root, t_act = root/2,
// timed drop hold. Optional zero-height guard enabled by DROP_SEQ_ZERO_HEIGHT_GUARD_EN.
module drop_sequencer #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   drop_sequencer_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StRoot, StCompare, StDrop, StZero} state_e;

   state_e      state_q;
   logic [31:0] rad_q;
   logic [19:0] rem_q;
   logic [15:0] root_q;
   logic [3:0]  iter_q;
   logic [15:0] tlim_q;
   logic        en_q;
   logic [7:0]  hold_q;
   logic [15:0] tact_q;
   logic        done_q;
   logic        drop_q;

   logic [19:0] rem_shift;
   logic [19:0] trial;
   logic        rem_ge;
   logic [19:0] rem_d;
   logic [15:0] root_d;
   logic [15:0] half_root;
   logic        hit;

   // One restoring-root step: bring in the next two radicand bits and try {root, 01}.
   always_comb begin
      rem_shift = {rem_q[17:0], rad_q[31:30]};
      trial     = {2'b00, root_q, 2'b01};
      rem_ge    = (rem_shift >= trial);
      rem_d     = rem_ge ? (rem_shift - trial) : rem_shift;
      root_d    = {root_q[14:0], rem_ge};
      half_root = {1'b0, root_q[15:1]};
      hit       = en_q && (half_root <= tlim_q);
   end

`ifdef DROP_SEQ_ZERO_HEIGHT_GUARD_EN
   logic err_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         iter_q  <= '0;
         tlim_q  <= '0;
         en_q    <= 1'b0;
         hold_q  <= '0;
         tact_q  <= '0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
`ifdef DROP_SEQ_ZERO_HEIGHT_GUARD_EN
         err_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (state_q != StIdle && bus.abort) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (bus.start && !bus.abort) begin
                     tlim_q <= bus.t_lim;
                     en_q   <= bus.drop_en;
                     rad_q  <= {bus.height, 16'h0000};
                     rem_q  <= '0;
                     root_q <= '0;
                     iter_q <= '0;
`ifdef DROP_SEQ_ZERO_HEIGHT_GUARD_EN
                     err_q  <= 1'b0;
                     state_q <= (bus.height == 8'd0) ? StZero : StRoot;
`else
                     state_q <= StRoot;
`endif
                  end
               end
               StRoot: begin
                  rad_q  <= {rad_q[29:0], 2'b00};
                  rem_q  <= rem_d;
                  root_q <= root_d;
                  iter_q <= iter_q + 4'd1;
                  if (iter_q == 4'd15) state_q <= StCompare;
               end
               StCompare: begin
                  tact_q <= half_root;
                  done_q <= 1'b1;
                  if (hit) begin
                     drop_q  <= 1'b1;
                     hold_q  <= 8'(HOLD_CYCLES);
                     state_q <= StDrop;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               StDrop: begin
                  if (hold_q <= 8'd1) begin
                     drop_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     hold_q <= hold_q - 8'd1;
                  end
               end
`ifdef DROP_SEQ_ZERO_HEIGHT_GUARD_EN
               StZero: begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  tact_q  <= '0;
                  state_q <= StIdle;
               end
`endif
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.busy           = (state_q != StIdle);
   assign bus.done           = done_q;
   assign bus.t_act          = tact_q;
   assign bus.drop_activated = drop_q;
`ifdef DROP_SEQ_ZERO_HEIGHT_GUARD_EN
   assign bus.err            = err_q;
`else
   assign bus.err            = 1'b0;
`endif

endmodule

// File: doc/drop_sequencer.md
# drop_sequencer

Sequential controller for the baggage-drop datapath. On a start request it captures the sensor-derived height, the time limit and the drop enable, then runs a one-bit-per-cycle integer square root in 8.8 fixed point and forms t_act = root/2. It then decides the drop and holds `drop_activated` for a programmable number of cycles. It sits between the sensor front end and the display/drop stage, replacing the combinational root-and-compare path with a sequenced, abortable one.

## Interface
- `HOLD_CYCLES`, default 4: cycles `drop_activated` stays high after a positive decision; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: measurement request; only sampled in IDLE.
- `abort` in 1: synchronous cancel; acts in any non-IDLE state.
- `height` in 8: unsigned height; captured when `start` is accepted.
- `t_lim` in 16: time limit in 8.8; captured when `start` is accepted.
- `drop_en` in 1: drop permission; captured when `start` is accepted.
- `busy` out 1: high while not in IDLE.
- `done` out 1: one-cycle pulse when `t_act` is updated.
- `t_act` out 16: last computed time, 8.8, registered.
- `drop_activated` out 1: drop command, registered.
- `err` out 1: zero-height flag. Present only with the macro (see Configuration); tied 0 otherwise.

## Operation
- States: IDLE, ROOT, COMPARE, DROP.
- **IDLE:** if `start`=1 and `abort`=0 at an edge:
  - capture `height`, `t_lim`, `drop_en`;
  - load radicand = {height, 16'h0000} (32 bits);
  - clear the remainder, root and iteration counter;
  - go to ROOT.
- **ROOT:** restoring bit-serial square root, exactly 16 iterations, one per edge.
  - Per iteration: rem = {rem, next 2 radicand MSBs}; trial = {root, 2'b01}.
  - If rem >= trial: rem -= trial, root = {root, 1}; else root = {root, 0}.
  - Result: root = floor(sqrt(height*65536)), i.e. sqrt(height) in 8.8, at most 16'h0FF7.
  - After the 16th iteration go to COMPARE.
- **COMPARE**, one edge:
  - `t_act` <= root >> 1 (bit 15 always 0);
  - `done` <= 1;
  - if captured `drop_en`=1 and (root>>1) <= captured `t_lim` (unsigned): `drop_activated` <= 1, load hold counter with HOLD_CYCLES, go to DROP;
  - otherwise go to IDLE.
- **DROP:** decrement the hold counter each edge. When it reaches 1, clear `drop_activated` and go to IDLE.
- `start` while busy: ignored, no queuing.
- **abort** (non-IDLE): next edge goes to IDLE, `drop_activated` <= 0, `done` stays 0, `t_act` keeps its previous value. In IDLE, abort=1 blocks start acceptance.
- Captured inputs are unaffected by input changes during the measurement.

## Timing
- Reset (async assert): state IDLE; `busy`, `done`, `drop_activated`, `err` = 0; `t_act` = 16'h0000; counters 0. Reset mid-measurement discards everything.
- Edge E0 accepts `start`; `busy`=1 after E0.
- E1..E16 perform the root iterations; E17 executes COMPARE.
- `done` and the new `t_act` are visible after E17, i.e. 17-cycle latency, and `done` lasts exactly one cycle.
- On a positive decision, `drop_activated` is high after E17 for exactly HOLD_CYCLES cycles. `busy` falls in the same cycle `drop_activated` falls.
- No drop: `busy` falls after E17, and the next `start` can be accepted at E18.
- `abort` sampled at edge Ek drops `busy` after Ek.

## Configuration
- Macro `DROP_SEQ_ZERO_HEIGHT_GUARD_EN`.
- **Defined:** a start with `height`=0 is still accepted, but the FSM skips ROOT and COMPARE.
  - Next edge: `err`=1 and `done`=1 for one cycle; `t_act` is set to 0; no drop; return to IDLE.
  - `busy` is high for one cycle.
  - `err` clears on the next accepted start or on reset.
- **Undefined:** `err` port is tied 0. Height 0 follows the normal path, giving `t_act`=0, so the drop fires whenever `drop_en`=1.

## Test plan
- height=100, t_lim=16'h0500, drop_en=1, pulse start -> after 17 edges `t_act`=16'h0500, `done` pulse, `drop_activated` high for 4 cycles, then `busy`=0.
- Same, but t_lim=16'h04FF -> `t_act`=16'h0500, `done` pulse, `drop_activated` stays 0, `busy` falls after E17.
- height=2 then height=255, t_lim=16'hFFFF, drop_en=0 -> `t_act`=16'h00B5, then `t_act`=16'h07FB; no drop in either run.
- Start at height=100; at E8 assert abort and change height and start -> `busy`=0 after E8, no `done`, `t_act` unchanged. A following clean start with height=100 gives 16'h0500.
- During DROP, pulse start, then assert `rst_n`=0 asynchronously -> start ignored; reset immediately clears `drop_activated`, `busy` and `t_act` to 0.
- With the macro, height=0 and start -> one-cycle `busy`, `err`=1, `done`=1, `t_act`=0, no drop. Without the macro, height=0 and drop_en=1 -> drop fires after E17.
